// File: rtl/regfile_req_ctrl.sv
// Request/response controller for the single-port byte-maskable register-file macro:
// optional zero-fill sweep after reset, then valid/ready requests with a 2-entry FWFT read buffer.
module regfile_req_ctrl #(
  parameter int unsigned BIT_WIDTH  = 128,
  parameter int unsigned WORD_DEPTH = 64,
  parameter bit          INIT_EN    = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_we_i,
  input  logic [$clog2(WORD_DEPTH)-1:0] req_addr_i,
  input  logic [BIT_WIDTH/8-1:0]        req_wstrb_i,
  input  logic [BIT_WIDTH-1:0]          req_wdata_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [BIT_WIDTH-1:0]          rsp_rdata_o,
  output logic                          init_done_o,
  output logic                          mem_en_o,
  output logic                          mem_wen_o,
  output logic [BIT_WIDTH/8-1:0]        mem_bm_o,
  output logic [$clog2(WORD_DEPTH)-1:0] mem_addr_o,
  output logic [BIT_WIDTH-1:0]          mem_dat_o,
  input  logic [BIT_WIDTH-1:0]          mem_dat_i
);

  localparam int unsigned AW = $clog2(WORD_DEPTH);
  localparam int unsigned SW = BIT_WIDTH / 8;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               r_state;
  logic [AW-1:0]        r_cnt;
  logic                 r_rd_inflight;
  logic [BIT_WIDTH-1:0] r_fifo [2];
  logic                 r_wptr;
  logic                 r_rptr;
  logic [1:0]           r_count;

  logic w_run;
  logic w_credit;
  logic w_fire;
  logic w_rd_fire;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // A request is only accepted when the buffer can absorb every outstanding read.
  assign w_run       = (r_state == ST_RUN);
  assign w_credit    = (r_count + 2'(r_rd_inflight)) < 2'd2;
  assign req_ready_o = w_run & ~rst_i & w_credit;
  assign w_fire      = req_valid_i & req_ready_o;
  assign w_rd_fire   = w_fire & ~req_we_i;
  assign init_done_o = w_run;

  // Read data bypasses the buffer when it is empty and the consumer is ready.
  assign w_empty     = (r_count == 2'd0);
  assign w_pop       = ~w_empty & rsp_ready_i;
  assign w_push      = r_rd_inflight & ~(w_empty & rsp_ready_i);
  assign rsp_valid_o = ~rst_i & (~w_empty | r_rd_inflight);
  assign rsp_rdata_o = w_empty ? mem_dat_i : r_fifo[r_rptr];

  // Macro pin drive: zero-fill sweep in INIT, request pass-through in RUN.
  always_comb begin
    mem_en_o   = 1'b1;
    mem_wen_o  = 1'b1;
    mem_bm_o   = '1;
    mem_addr_o = '0;
    mem_dat_o  = '0;
    if (!w_run) begin
      mem_en_o   = 1'b0;
      mem_wen_o  = 1'b0;
      mem_bm_o   = '0;
      mem_addr_o = r_cnt;
    end else if (w_fire) begin
      mem_en_o   = 1'b0;
      mem_wen_o  = ~req_we_i;
      mem_addr_o = req_addr_i;
      if (req_we_i) begin
        mem_dat_o = req_wdata_i;
        mem_bm_o  = ~req_wstrb_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= INIT_EN ? ST_INIT : ST_RUN;
      r_cnt         <= '0;
      r_rd_inflight <= 1'b0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_count       <= 2'd0;
    end else begin
      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + AW'(1);
        if (r_cnt == AW'(WORD_DEPTH - 1)) r_state <= ST_RUN;
      end
      r_rd_inflight <= w_rd_fire;
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  // Buffer storage carries no reset; validity is tracked by r_count.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) r_fifo[r_wptr] <= mem_dat_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && (r_count == 2'd2)));

  logic [SW-1:0] w_unused_sw;
  assign w_unused_sw = '0;

endmodule
